// File: rtl/time_set_pkg.sv
// Shared types, field limits and wrap arithmetic for the time-set controller.
package time_set_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EDIT_H,
    EDIT_M,
    EDIT_S,
    COMMIT
  } state_t;

  localparam logic [5:0] HOUR_MAX   = 6'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  localparam logic [1:0] FS_IDLE    = 2'd0;
  localparam logic [1:0] FS_HOURS   = 2'd1;
  localparam logic [1:0] FS_MINUTES = 2'd2;
  localparam logic [1:0] FS_SECONDS = 2'd3;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0 || v > max) ? max : v - 6'd1;
  endfunction

  // Out-of-range running time is not trusted as an edit seed.
  function automatic logic [5:0] capture(input logic [5:0] v, input logic [5:0] max);
    return (v > max) ? 6'd0 : v;
  endfunction

  // Opposing steps in the same cycle cancel.
  function automatic logic [5:0] apply_step(input logic [5:0] v, input logic [5:0] max,
                                            input logic up, input logic dn);
    logic [5:0] r;
    r = v;
    if (up && !dn) r = wrap_inc(v, max);
    else if (dn && !up) r = wrap_dec(v, max);
    return r;
  endfunction

endpackage

// File: rtl/btn_step.sv
// Registered rising-edge detector for a debounced button, with optional
// auto-repeat while the button stays held.
module btn_step #(
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic step_o
);

  localparam int CW = $clog2(REPEAT_DELAY + 1);

  logic          prev_q;
  logic          arm_q;
  logic          arm_d;
  logic          step_q;
  logic          step_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          rise;
  logic          held;

  // arm_q stays low until the button has been seen released after reset,
  // so a level held through reset release never counts as a press.
  always_comb begin
    arm_d  = arm_q | ~btn_i;
    rise   = btn_i & ~prev_q & arm_q;
    held   = btn_i & prev_q & arm_q;
    step_d = rise;
    cnt_d  = '0;
    if (REPEAT_EN) begin
      if (rise) begin
        cnt_d = CW'(1);
      end else if (held) begin
        if (cnt_q == CW'(REPEAT_DELAY)) begin
          step_d = 1'b1;
          // Reloading here makes the next match land REPEAT_PERIOD cycles later.
          cnt_d  = CW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
      step_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= btn_i;
      arm_q  <= arm_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/time_setter.sv
// Time-set controller: turns mode/inc/dec buttons into the load interface
// (set_mod plus edit values) of the hours/minutes/seconds timekeeper.
module time_setter
  import time_set_pkg::*;
#(
  parameter int COMMIT_HOLD   = 50000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic       set_mod,
  output logic [5:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic [1:0] field_sel
);

  localparam int HCW = $clog2(COMMIT_HOLD + 1);

  logic           mode_step;
  logic           inc_step;
  logic           dec_step;
  state_t         state_q;
  logic           set_mod_q;
  logic [1:0]     field_q;
  logic [5:0]     hours_q;
  logic [5:0]     minutes_q;
  logic [5:0]     seconds_q;
  logic [HCW-1:0] hold_q;

  btn_step #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b0)
  ) u_mode (
    .clk   (clk),
    .reset (reset),
    .btn_i (btn_mode),
    .step_o(mode_step)
  );

  btn_step #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b1)
  ) u_inc (
    .clk   (clk),
    .reset (reset),
    .btn_i (btn_inc),
    .step_o(inc_step)
  );

  btn_step #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b1)
  ) u_dec (
    .clk   (clk),
    .reset (reset),
    .btn_i (btn_dec),
    .step_o(dec_step)
  );

  // Outputs are registered alongside the state so they change with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      set_mod_q <= 1'b0;
      field_q   <= FS_IDLE;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      hold_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          set_mod_q <= 1'b0;
          field_q   <= FS_IDLE;
          if (mode_step) begin
            hours_q   <= capture(cur_hours, HOUR_MAX);
            minutes_q <= capture(cur_minutes, MINSEC_MAX);
            seconds_q <= capture(cur_seconds, MINSEC_MAX);
            set_mod_q <= 1'b1;
            field_q   <= FS_HOURS;
            state_q   <= EDIT_H;
          end
        end
        EDIT_H: begin
          if (mode_step) begin
            field_q <= FS_MINUTES;
            state_q <= EDIT_M;
          end else begin
            hours_q <= apply_step(hours_q, HOUR_MAX, inc_step, dec_step);
          end
        end
        EDIT_M: begin
          if (mode_step) begin
            field_q <= FS_SECONDS;
            state_q <= EDIT_S;
          end else begin
            minutes_q <= apply_step(minutes_q, MINSEC_MAX, inc_step, dec_step);
          end
        end
        EDIT_S: begin
          if (mode_step) begin
            field_q <= FS_IDLE;
            hold_q  <= '0;
            state_q <= COMMIT;
          end else begin
            seconds_q <= apply_step(seconds_q, MINSEC_MAX, inc_step, dec_step);
          end
        end
        COMMIT: begin
          // Keep the load asserted long enough for the slow timekeeper to sample it.
          if (hold_q == HCW'(COMMIT_HOLD - 1)) begin
            set_mod_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            hold_q <= hold_q + HCW'(1);
          end
        end
        default: begin
          set_mod_q <= 1'b0;
          field_q   <= FS_IDLE;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign set_mod     = set_mod_q;
  assign field_sel   = field_q;
  assign set_hours   = hours_q;
  assign set_minutes = minutes_q;
  assign set_seconds = seconds_q;

endmodule

// File: doc/time_setter.md
Name: time_setter

Overview:
User-facing time-set controller that drives the load side of the hours/minutes/seconds timekeeper.
- Turns debounced mode/inc/dec buttons into set_mod plus set_hours/set_minutes/set_seconds.
- Seeds the edit values from the running time, then walks the fields H→M→S and commits.
- Runs on the fast system clock and holds set_mod long enough for the 1 Hz timekeeper to sample it.

Parameters:
COMMIT_HOLD, 50000000, clk cycles set_mod stays high after the last field is confirmed (≥ one 1 Hz period).
REPEAT_DELAY, 25000000, clk cycles inc/dec must be held before auto-repeat starts.
REPEAT_PERIOD, 5000000, clk cycles between auto-repeat steps.

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
btn_mode  in  1  debounced level, advance field / enter / commit
btn_inc  in  1  debounced level, increment current field
btn_dec  in  1  debounced level, decrement current field
cur_hours  in  6  running time from timekeeper, 0..23
cur_minutes  in  6  running time, 0..59
cur_seconds  in  6  running time, 0..59
set_mod  out  1  load enable to timekeeper
set_hours  out  6  edit value, hours
set_minutes  out  6  edit value, minutes
set_seconds  out  6  edit value, seconds
field_sel  out  2  0 idle, 1 hours, 2 minutes, 3 seconds (display blink select)

Behaviour:
- Reset (synchronous, at clk edge with reset=1): state IDLE; set_mod=0; set_hours/minutes/seconds=0; field_sel=0; repeat and commit counters=0; button history regs=0. Reset mid-edit or mid-commit aborts with no further load.
- Button events: registered rising-edge detection, so an event registers one cycle after the input rises. A level held from before reset release produces no event.
- Auto-repeat (inc/dec only): an edge gives one step. If held continuously, the first repeat step fires REPEAT_DELAY cycles after the edge, then one step every REPEAT_PERIOD cycles. Release clears the counter.
- States:
  - IDLE: set_mod=0, field_sel=0. On a mode event, capture cur_* into the edit regs; any captured value above its max loads 0. Go to EDIT_H.
  - EDIT_H, EDIT_M, EDIT_S: set_mod=1; field_sel=1/2/3. An inc/dec step modifies only the selected field. A mode event advances H→M→S→COMMIT.
  - COMMIT: set_mod=1, field_sel=0. Count COMMIT_HOLD cycles, then go to IDLE with set_mod=0 on the following cycle. Mode, inc and dec are ignored.
- Arithmetic (edit regs, applied in the cycle after the step event):
  - hours modulo 24: 23+1→0, 0−1→23.
  - minutes and seconds modulo 60: 59+1→0, 0−1→59.
- Simultaneous events:
  - inc and dec steps in the same cycle: no change.
  - mode together with inc/dec: the field advances and the step is discarded.
- set_* outputs are the edit regs, driven continuously. They hold their last value in IDLE.
- set_mod is high for the whole edit, so the timekeeper stays frozen at the edit values. Time resumes counting from the committed value after set_mod falls.
- All outputs are registered. No combinational path from any input to any output.

Decomposition:
- Package time_set_pkg:
  - state enum {IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT}
  - HOUR_MAX=23, MINSEC_MAX=59
  - field_sel encodings
  - wrap-increment/decrement function taking the max value
- Sub-module btn_step: edge detect plus auto-repeat with parameters REPEAT_DELAY/REPEAT_PERIOD and an enable-repeat parameter.
  - Two instances (inc, dec) with repeat enabled.
  - btn_mode uses the same module with repeat disabled.
- Top-level time_setter contains the FSM, edit regs and commit counter.

Test Plan:
Bench uses COMMIT_HOLD=8, REPEAT_DELAY=6, REPEAT_PERIOD=2.
1. Enter and commit with no edits: cur=12:34:56; mode pulse ×4. set_mod rises one cycle after the first event with set=12:34:56 and field_sel 1→2→3→0. set_mod stays high 8 cycles in COMMIT, then falls.
2. Hours wrap: cur=23:00:00; mode, inc → set_hours=0; dec → 23; dec ×24 → 23. Minutes and seconds unchanged.
3. Auto-repeat in EDIT_M from 58: hold inc 12 cycles. Steps at edge, edge+6, +8, +10 give 59,0,1,2. Release gives no further change.
4. Simultaneous inc+dec rising in EDIT_S at 30 → stays 30. Mode plus inc together in EDIT_H → field_sel=2, hours unchanged.
5. Reset mid-COMMIT (cycle 3 of 8) → next cycle set_mod=0, field_sel=0, set_*=0, IDLE. btn_mode already high at reset release → no entry until the next rising edge.
6. Out-of-range capture: cur_hours=30, cur_minutes=61 → set_hours=0, set_minutes=0 on entry to EDIT_H.
